// File: rtl/dma_ctrl.sv
// Byte-wide RAM access controller: queues single-byte read/write requests in a
// small FIFO and executes them in order on a single-port synchronous RAM.
module dma_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              done_read,
    output logic              done_write,
    output logic [15:0]       write_count,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RWAIT = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  fifo_d [FIFO_DEPTH];
    logic              req_ready_q, req_ready_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              done_read_q, done_read_d;
    logic [15:0]       write_count_q, write_count_d;

    logic              push, pop, empty, full_d;
    logic [ENT_W-1:0]  head;

    // Handshake: a request transfers on any rising edge where req_valid and
    // req_ready are both 1; req_ready comes straight from a flop, so it never
    // depends on req_valid, and a stalled requester must hold its request.
    assign push  = req_valid && req_ready_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = (state_q == IDLE) && !empty;
    assign head  = fifo_q[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            req_ready_q   <= 1'b0;
            op_write_q    <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            rd_data_q     <= '0;
            done_read_q   <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            req_ready_q   <= req_ready_d;
            op_write_q    <= op_write_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            rd_data_q     <= rd_data_d;
            done_read_q   <= done_read_d;
            write_count_q <= write_count_d;
        end
    end

    // Entries are qualified by the pointers, so the storage needs no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q[IDX_W-1:0]] = {req_write, req_addr, req_wdata};
            wr_ptr_d = wr_ptr_q + {{IDX_W{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{IDX_W{1'b0}}, 1'b1};
        end
        full_d = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                 (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
        req_ready_d = !full_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = ISSUE;
            ISSUE:   state_d = op_write_q ? IDLE : RWAIT;
            RWAIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_write_d    = op_write_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        rd_data_d     = rd_data_q;
        done_read_d   = 1'b0;
        write_count_d = write_count_q;
        if (pop) begin
            {op_write_d, ram_addr_d, ram_wdata_d} = head;
        end
        if (state_q == ISSUE && op_write_q) begin
            write_count_d = write_count_q + 16'd1;
        end
        // RAM read data is valid during RWAIT; present it one cycle later.
        if (state_q == RWAIT) begin
            rd_data_d   = ram_rdata;
            done_read_d = 1'b1;
        end
    end

    always_comb begin
        ram_en     = (state_q == ISSUE);
        ram_we     = (state_q == ISSUE) && op_write_q;
        done_write = (state_q == ISSUE) && op_write_q;
    end

    assign req_ready   = req_ready_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign rd_data     = rd_data_q;
    assign done_read   = done_read_q;
    assign write_count = write_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a behavioural RAM, an access monitor and an
// expected-access queue.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [7:0]  rd_data;
  logic        done_read, done_write;
  logic [15:0] write_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  logic [24:0] act_q[$];
  logic [7:0]  rd_q[$];
  int n_rd = 0, n_wr = 0, n_both = 0, n_wide = 0;
  logic prev_dr = 1'b0, prev_dw = 1'b0;
  logic [7:0] mem [0:65535];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dma_ctrl #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rd_data(rd_data), .done_read(done_read),
    .done_write(done_write), .write_count(write_count), .dbg_state(dbg_state)
  );

  // Single-port synchronous RAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Monitor: logs accesses and done pulses away from the active edge
  always @(negedge clk) begin
    if (ram_en === 1'b1) act_q.push_back({ram_we, ram_addr, ram_wdata});
    if (done_read === 1'b1) begin n_rd++; rd_q.push_back(rd_data); end
    if (done_write === 1'b1) n_wr++;
    if (done_read === 1'b1 && done_write === 1'b1) n_both++;
    if ((done_read === 1'b1 && prev_dr) || (done_write === 1'b1 && prev_dw)) n_wide++;
    prev_dr = (done_read === 1'b1);
    prev_dw = (done_write === 1'b1);
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    exp_q.push_back({w, a, d});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_done_rd"}, 32'(done_read), 32'd0);
    chk({tag, "_done_wr"}, 32'(done_write), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_wcount"}, 32'(write_count), 32'd0);
  endtask

  // Read accesses carry don't-care write data, so only {we,addr} is compared for them.
  task automatic compare_accesses(input string tag);
    logic [24:0] e, a;
    chk({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      if (e[24]) chk({tag, "_access"}, 32'(a), 32'(e));
      else       chk({tag, "_access"}, 32'(a[24:8]), 32'(e[24:8]));
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1; req_valid = 1'b0;
    step(3);
    RST = 1'b0;
    exp_q.delete(); act_q.delete(); rd_q.delete();
    step(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int snap_rd, snap_wr, n;
    logic saw_busy;

    // Power-on reset
    step(3);
    check_idle_outputs("por");
    RST = 1'b0;
    chk("por_ready_before_edge", 32'(req_ready), 32'd0);
    step(1);
    chk("por_ready_after_release", 32'(req_ready), 32'd1);

    // Reset during active traffic: two reads queued, one in flight
    send(1'b0, 16'h0100, 8'h00);
    send(1'b0, 16'h0101, 8'h00);
    RST = 1'b1;
    snap_rd = n_rd; snap_wr = n_wr;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_idle_outputs("rst_mid");
    end
    RST = 1'b0;
    exp_q.delete(); act_q.delete(); rd_q.delete();
    chk("rst_ready_before_edge", 32'(req_ready), 32'd0);
    step(1);
    chk("rst_ready_after_release", 32'(req_ready), 32'd1);
    step(8);
    chk("rst_no_done_read", 32'(n_rd), 32'(snap_rd));
    chk("rst_no_done_write", 32'(n_wr), 32'(snap_wr));
    chk("rst_no_access", 32'(act_q.size()), 32'd0);

    // Single write: RAM cycle and done_write two edges after accept
    chk("wr_count_start", 32'(write_count), 32'd0);
    send(1'b1, 16'h000F, 8'hA5);
    chk("wr_no_early_en", 32'(ram_en), 32'd0);
    chk("wr_no_early_done", 32'(done_write), 32'd0);
    step(1);
    chk("wr_ram_en", 32'(ram_en), 32'd1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h000F);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
    chk("wr_done", 32'(done_write), 32'd1);
    step(1);
    chk("wr_done_one_cycle", 32'(done_write), 32'd0);
    chk("wr_ram_en_off", 32'(ram_en), 32'd0);
    chk("wr_count_one", 32'(write_count), 32'd1);
    chk("wr_addr_held", 32'(ram_addr), 32'h000F);
    compare_accesses("single_wr");

    // Write then read back: done_read four edges after accept
    send(1'b1, 16'h0010, 8'h3C);
    step(3);
    send(1'b0, 16'h0010, 8'h00);
    chk("rd_done_n1", 32'(done_read), 32'd0);
    step(1);
    chk("rd_ram_en", 32'(ram_en), 32'd1);
    chk("rd_ram_we", 32'(ram_we), 32'd0);
    chk("rd_ram_addr", 32'(ram_addr), 32'h0010);
    chk("rd_done_n2", 32'(done_read), 32'd0);
    step(1);
    chk("rd_wait_en", 32'(ram_en), 32'd0);
    chk("rd_done_n3", 32'(done_read), 32'd0);
    step(1);
    chk("rd_done", 32'(done_read), 32'd1);
    chk("rd_data", 32'(rd_data), 32'h3C);
    step(1);
    chk("rd_done_one_cycle", 32'(done_read), 32'd0);
    send(1'b1, 16'h0011, 8'h77);
    step(4);
    chk("rd_data_held", 32'(rd_data), 32'h3C);
    chk("rd_wcount", 32'(write_count), 32'd3);
    compare_accesses("wr_rd");

    // Burst of 10 writes with req_valid held high
    do_reset();
    saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 16'h000F + 16'(i); req_wdata = 8'h40 + 8'(i);
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin saw_busy = 1'b1; @(negedge clk); n++; end
      if (n >= 200) chk("burst_timeout", 32'(n), 32'd0);
      @(posedge clk);
      exp_q.push_back({1'b1, req_addr, req_wdata});
      @(negedge clk);
    end
    req_valid = 1'b0;
    step(12);
    chk("burst_ready_dropped", 32'(saw_busy), 32'd1);
    chk("burst_wcount", 32'(write_count), 32'd10);
    chk("burst_ready_back", 32'(req_ready), 32'd1);
    compare_accesses("burst");

    // Mixed W,R,W,R with random gaps
    send(1'b1, 16'h0020, 8'h11);
    step($urandom_range(0, 3));
    send(1'b0, 16'h0020, 8'h00);
    step($urandom_range(0, 3));
    send(1'b1, 16'h0021, 8'h22);
    step($urandom_range(0, 3));
    send(1'b0, 16'h0021, 8'h00);
    step(10);
    chk("mix_rd_count", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() == 2) begin
      chk("mix_rd0", 32'(rd_q[0]), 32'h11);
      chk("mix_rd1", 32'(rd_q[1]), 32'h22);
    end
    chk("mix_wcount", 32'(write_count), 32'd12);
    compare_accesses("mixed");

    // write_count wrap from 0xFFFF
    force dut.write_count_q = 16'hFFFF;
    #1;
    release dut.write_count_q;
    step(2);
    chk("wrap_preload", 32'(write_count), 32'hFFFF);
    send(1'b1, 16'h0030, 8'h5A);
    step(3);
    chk("wrap_zero", 32'(write_count), 32'h0000);
    compare_accesses("wrap");

    chk("never_both_done", 32'(n_both), 32'd0);
    chk("done_one_cycle_wide", 32'(n_wide), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
